// File: rtl/tau_register_file.sv
// ---------------------------------------------------------------------------
// tau_register_file
//   8-entry general-purpose register file for the tau core. One write-back
//   port from the ALU, and a registered operand stage that delivers an A/B
//   operand pair through a valid/ready handshake.
//
// Ports
//   clk        core clock, all state changes on the rising edge
//   reset      synchronous, active-high reset
//   wr_en      write-back strobe
//   wr_sel     destination register index
//   wr_data    write-back value
//   req_valid  operand-fetch request present
//   req_ready  operand stage can take a request this cycle (combinational)
//   sel_a      side-A register index
//   sel_b      side-B selector: 0-7 register, 8 imm8, 9-15 reads zero
//   imm8       immediate, sampled together with the request
//   op_valid   op_a/op_b hold a valid operand pair
//   op_ready   ALU consumes the operand pair
//   op_a       side-A operand (registered)
//   op_b       side-B operand (registered)
// ---------------------------------------------------------------------------
module tau_register_file #(
    parameter int WORD_SIZE = 8,
    parameter int NUM_REGS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [2:0]           wr_sel,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           sel_a,
    input  logic [3:0]           sel_b,
    input  logic [WORD_SIZE-1:0] imm8,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [WORD_SIZE-1:0] op_a,
    output logic [WORD_SIZE-1:0] op_b
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];

    state_t               state_q;
    logic [WORD_SIZE-1:0] op_a_q;
    logic [WORD_SIZE-1:0] op_b_q;

    logic [WORD_SIZE-1:0] op_a_d;
    logic [WORD_SIZE-1:0] op_b_d;
    logic                 accept;

    // ------------------------------------------------------------------
    // Register array. R0 is an ordinary register; writes are independent
    // of the operand handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_sel] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Operand source selection with write-to-read forwarding. A write
    // landing in the same cycle as the read is bypassed so the operand
    // pair never sees a stale value. Forwarding only covers register
    // selections, never imm8 or the zero selections.
    // ------------------------------------------------------------------
    always_comb begin
        op_a_d = regs_q[sel_a];
        if (wr_en && (wr_sel == sel_a)) begin
            op_a_d = wr_data;
        end

        op_b_d = '0;
        if (!sel_b[3]) begin
            op_b_d = regs_q[sel_b[2:0]];
            if (wr_en && (wr_sel == sel_b[2:0])) begin
                op_b_d = wr_data;
            end
        end else if (sel_b[2:0] == 3'd0) begin
            op_b_d = imm8;
        end
    end

    // The stage can refill in the same cycle the ALU drains it, giving one
    // pair per cycle without bubbles.
    assign req_ready = (state_q == EMPTY) || op_ready;
    assign accept    = req_valid && req_ready;

    // ------------------------------------------------------------------
    // Operand stage. The operand registers only load on accept, so a
    // stalled pair is a snapshot: later writes to its source registers do
    // not disturb it, and a consumed pair keeps its last value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            if (accept) begin
                op_a_q <= op_a_d;
                op_b_q <= op_b_d;
            end
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (op_ready && !accept) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign op_valid = (state_q == FULL);
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;

endmodule

// File: tb/tb_tau_register_file.sv
// ---------------------------------------------------------------------------
// tb_tau_register_file
//   Self-checking bench for tau_register_file. A reference model tracks the
//   register contents and operand-stage occupancy; every accepted request
//   pushes its expected operand pair onto a scoreboard queue, which is
//   popped and compared when the pair is consumed. Directed checks with
//   literal values cover the documented scenarios.
// ---------------------------------------------------------------------------
module tb_tau_register_file;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_sel;
    logic [7:0] wr_data;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] sel_a;
    logic [3:0] sel_b;
    logic [7:0] imm8;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;

    tau_register_file #(
        .WORD_SIZE (8),
        .NUM_REGS  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .imm8      (imm8),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [7:0]  m_regs [8];
    logic        m_valid;
    logic [15:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [2:0] idx, input logic we,
                                          input logic [2:0] ws, input logic [7:0] wd);
        if (we && ws == idx) return wd;
        return m_regs[idx];
    endfunction

    // One clock cycle: drive inputs after the falling edge, check the
    // combinational ready and any consumed pair, advance the model at the
    // rising edge, then check occupancy at the next falling edge.
    task automatic step(input logic rst, input logic we, input logic [2:0] ws,
                        input logic [7:0] wd, input logic rv, input logic [2:0] sa,
                        input logic [3:0] sb, input logic [7:0] im, input logic ordy);
        logic       exp_ready;
        logic       acc;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [15:0] pair;
        reset = rst; wr_en = we; wr_sel = ws; wr_data = wd;
        req_valid = rv; sel_a = sa; sel_b = sb; imm8 = im; op_ready = ordy;
        #1;
        exp_ready = !m_valid || ordy;
        check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        if (m_valid && ordy && !rst) begin
            check("sb_depth", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                pair = sb_q.pop_front();
                check("sb_op_a", {24'd0, op_a}, {24'd0, pair[15:8]});
                check("sb_op_b", {24'd0, op_b}, {24'd0, pair[7:0]});
                $display("consume a=0x%02h b=0x%02h", op_a, op_b);
            end
        end
        acc = rv && exp_ready && !rst;
        if (acc) begin
            ea = m_read(sa, we, ws, wd);
            if (sb < 4'd8)       eb = m_read(sb[2:0], we, ws, wd);
            else if (sb == 4'd8) eb = im;
            else                 eb = 8'h00;
            sb_q.push_back({ea, eb});
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
            m_valid = 1'b0;
            sb_q.delete();
        end else begin
            if (we) m_regs[ws] = wd;
            if (acc)       m_valid = 1'b1;
            else if (ordy) m_valid = 1'b0;
        end
        @(negedge clk);
        check("op_valid", {31'd0, op_valid}, {31'd0, m_valid});
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 8'h00, ordy);
    endtask

    task automatic wr(input logic [2:0] ws, input logic [7:0] wd);
        step(1'b0, 1'b1, ws, wd, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = 3'd0; wr_data = 8'h00;
        req_valid = 1'b0; sel_a = 3'd0; sel_b = 4'd0; imm8 = 8'h00; op_ready = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_valid = 1'b0;
        @(negedge clk);

        // Reset state.
        step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0);
        check("rst_op_a", {24'd0, op_a}, 32'h00);
        check("rst_op_b", {24'd0, op_b}, 32'h00);

        // 1: register A, immediate B.
        wr(3'd3, 8'h5A);
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 4'd8, 8'h11, 1'b1);
        check("t1_valid", {31'd0, op_valid}, 32'd1);
        check("t1_op_a", {24'd0, op_a}, 32'h5A);
        check("t1_op_b", {24'd0, op_b}, 32'h11);
        idle(1'b1);

        // 2: forwarding on both sides.
        step(1'b0, 1'b1, 3'd5, 8'hC3, 1'b1, 3'd5, 4'd5, 8'h00, 1'b1);
        check("t2_op_a", {24'd0, op_a}, 32'hC3);
        check("t2_op_b", {24'd0, op_b}, 32'hC3);
        idle(1'b1);

        // 3: no-connect selector reads zero.
        wr(3'd4, 8'hFF);
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 4'd12, 8'h99, 1'b1);
        check("t3_op_a", {24'd0, op_a}, 32'hFF);
        check("t3_op_b", {24'd0, op_b}, 32'h00);
        idle(1'b1);

        // 4: stall snapshot, then consume-and-accept.
        wr(3'd1, 8'h10);
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 4'd1, 8'h00, 1'b0);
        check("t4_op_a", {24'd0, op_a}, 32'h10);
        step(1'b0, 1'b1, 3'd1, 8'h20, 1'b1, 3'd1, 4'd1, 8'h00, 1'b0);
        check("t4_hold_a", {24'd0, op_a}, 32'h10);
        check("t4_hold_ready", {31'd0, req_ready}, 32'd0);
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 4'd0, 8'h00, 1'b1);
        check("t4_b2b_valid", {31'd0, op_valid}, 32'd1);
        check("t4_new_a", {24'd0, op_a}, 32'h20);
        idle(1'b1);

        // 5: back-to-back reads of R0..R3.
        for (int i = 0; i < 4; i++) wr(3'(i), 8'(i + 1));
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 4'd8, 8'(8'hA0 + i), 1'b1);
            check("t5_valid", {31'd0, op_valid}, 32'd1);
            check("t5_op_a", {24'd0, op_a}, 32'(i + 1));
        end
        idle(1'b1);

        // 6: reset while full and writing.
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 4'd4, 8'h00, 1'b0);
        step(1'b1, 1'b1, 3'd2, 8'h77, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0);
        check("t6_valid", {31'd0, op_valid}, 32'd0);
        check("t6_op_a", {24'd0, op_a}, 32'h00);
        check("t6_op_b", {24'd0, op_b}, 32'h00);
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 4'd2, 8'h00, 1'b1);
        check("t6_r2_a", {24'd0, op_a}, 32'h00);
        check("t6_r2_b", {24'd0, op_b}, 32'h00);
        idle(1'b1);

        // Random traffic against the scoreboard.
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 63) == 0), 1'($urandom), 3'($urandom), 8'($urandom),
                 1'($urandom), 3'($urandom), 4'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) != 0));
        end
        idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tau_register_file.md
Name: tau_register_file

Overview:
- 8-entry general-purpose register file for the tau core.
- Receives ALU write-back on one write port.
- Supplies ALU side-A and side-B operands through a registered, valid/ready operand stage.
- Side B uses the same selector encoding as the ALU B-input path: 0-7 select registers R0-R7, 8 selects IMM8, 9-15 select no-connect (reads as zero).
- Write-to-read forwarding is built in, so a value written back in the same cycle it is read is seen immediately.

Parameters:
- WORD_SIZE, 8, width of each register, operand and immediate.
- NUM_REGS, 8, register count. Fixed at 8; the selector widths depend on it.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write-back strobe.
- wr_sel  in  3  destination register index.
- wr_data  in  WORD_SIZE  write-back value.
- req_valid  in  1  operand-fetch request present.
- req_ready  out  1  operand stage can accept a request this cycle (combinational).
- sel_a  in  3  side-A register index.
- sel_b  in  4  side-B selector (0-7 register, 8 IMM8, 9-15 zero).
- imm8  in  WORD_SIZE  immediate, sampled with the request.
- op_valid  out  1  op_a/op_b hold a valid operand pair.
- op_ready  in  1  ALU consumes the operand pair.
- op_a  out  WORD_SIZE  side-A operand (registered).
- op_b  out  WORD_SIZE  side-B operand (registered).

Behaviour:
- Reset:
  - R0-R7 cleared to 0.
  - op_valid=0, op_a=0, op_b=0.
  - Reset overrides a simultaneous write or request. A held, unconsumed operand pair is discarded.
- Write:
  - On a clock edge with wr_en=1 and reset=0, R[wr_sel] <= wr_data.
  - R0 is an ordinary writable register.
- Request ready: req_ready = !op_valid || op_ready.
- Request accept:
  - A request is accepted when req_valid && req_ready.
  - On that edge, op_a and op_b are loaded and op_valid <= 1.
  - Latency: operands are visible 1 cycle after acceptance.
- Operand sources:
  - op_a source is R[sel_a].
  - op_b source is R[sel_b[2:0]] when sel_b<8; imm8 when sel_b==8; 0 when sel_b>=9.
- Forwarding:
  - If wr_en=1 and wr_sel equals the register being read on the accepting cycle, that operand takes wr_data, not the old register contents.
  - Forwarding applies to each side independently; both sides may forward.
  - Forwarding never applies to the imm8 or zero selections.
- Consume and hold:
  - When op_valid && op_ready and no new request is accepted, op_valid <= 0 on the next edge.
  - op_a and op_b keep their last values; they are not cleared.
  - Back-to-back operation (consume plus accept in the same cycle) keeps op_valid=1 and loads the new pair. Throughput is 1 pair per cycle.
- Stall: while op_valid && !op_ready:
  - op_a and op_b are frozen (snapshot semantics).
  - A later write to the source register does not modify the held pair.
  - req_ready=0.
- Requests with req_valid=0 have no effect. Writes proceed independently of the handshake at all times.
- No internal FSM beyond the op_valid state. There are two states:
  - EMPTY (op_valid=0): moves to FULL on accept.
  - FULL (op_valid=1): moves to EMPTY on consume without accept; stays FULL on consume with accept or on stall.

Test Plan:
1. Reset, then write R3=0x5A. Next cycle request sel_a=3, sel_b=8, imm8=0x11 with op_ready=1 -> one cycle later op_valid=1, op_a=0x5A, op_b=0x11.
2. Same-cycle write R5=0xC3 and request sel_a=5, sel_b=5, with R5 previously 0x00 -> op_a=0xC3, op_b=0xC3 (forwarded on both sides).
3. Request sel_b=12 with R4=0xFF and sel_a=4 -> op_a=0xFF, op_b=0x00.
4. Hold op_ready=0 after op_valid rises with op_a=0x10 from R1, then write R1=0x20 -> op_a stays 0x10 and req_ready=0 until op_ready=1. A new request sel_a=1 accepted on the consume cycle -> next op_a=0x20 with op_valid continuously 1.
5. Issue back-to-back requests for 4 cycles with op_ready=1, reading R0..R3 preloaded with 1,2,3,4 -> op_a sequence 1,2,3,4 on consecutive cycles, no bubbles.
6. Assert reset while op_valid=1 and wr_en=1 writing R2=0x77 -> next cycle op_valid=0, op_a=op_b=0, and a subsequent read of R2 returns 0x00.
